// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider: per-channel square wave, rising-edge tick
// and shadowed half-period that is only applied at a counter wrap or while idle.
module clock_divider_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FREC_BASE   = 100,
  parameter int unsigned FREC_SALIDA = 25,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  localparam int unsigned      DEF_HALF = FREC_BASE / (2 * FREC_SALIDA);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEF_HALF);

  logic [DIV_W-1:0] cnt_q [N_CH];
  logic [DIV_W-1:0] cnt_d [N_CH];
  logic [DIV_W-1:0] act_q [N_CH];
  logic [DIV_W-1:0] act_d [N_CH];
  logic [DIV_W-1:0] sh_q  [N_CH];
  logic [DIV_W-1:0] sh_d  [N_CH];
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  run_c, wrap_c, wr_c;

  // Per-channel counter, output and divisor-apply logic
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = sh_q;
    clk_d  = clk_q;
    tick_d = '0;
    pend_d = pend_q;
    run_c  = '0;
    wrap_c = '0;
    wr_c   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      run_c[i]  = en[i] && (act_q[i] != '0);
      wrap_c[i] = run_c[i] && (cnt_q[i] == act_q[i] - DIV_W'(1));
      wr_c[i]   = cfg_we && (cfg_ch == CH_W'(i));

      if (!run_c[i]) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (wrap_c[i]) begin
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end

      // A write on an apply edge bypasses the shadow so the new period starts now
      if (wr_c[i]) begin
        sh_d[i] = cfg_div;
        if (!run_c[i] || wrap_c[i]) begin
          act_d[i]  = cfg_div;
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = 1'b1;
        end
      end else if (pend_q[i] && (!run_c[i] || wrap_c[i])) begin
        act_d[i]  = sh_q[i];
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_DIV;
        sh_q[i]  <= DEF_DIV;
      end
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule
